note_sequencer: RTL and testbench

Buffered melody sequencer that drives the speaker driver's 8-bit `Note` input. The OTTER MCU (or any host) pushes {note, duration} entries into an internal FIFO. The block plays them in order, holding each note code for an exact number of prescaled time ticks, then returns the output to silence (8'h00) when the FIFO drains. It sits between the OTTER MMIO write path and the speaker driver, so software no longer busy-waits for note timing.

---
 rtl/note_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_note_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: FIFO-buffered melody player driving the speaker driver's 8-bit note code.
// Define NOTE_SEQ_GAP_EN to compile in a silent GAP state of GAP_TICKS ticks after every note.
module note_sequencer #(
    parameter int DEPTH     = 16,
    parameter int TICK_DIV  = 1000000,
    parameter int GAP_TICKS = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WR,
    input  logic [15:0]            WR_DATA,
    input  logic                   STOP,
    output logic [7:0]             NOTE,
    output logic                   BUSY,
    output logic                   EMPTY,
    output logic                   FULL,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVF
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
`ifdef NOTE_SEQ_GAP_EN
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam bit         GAP_ON = (GAP_TICKS > 0);
    localparam logic [8:0] GAP_LOAD = 9'(GAP_TICKS);
`else
    // Without the gap feature GAP_TICKS has no effect.
    localparam bit         GAP_ON = 1'b0 & (GAP_TICKS != 0);
`endif

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;

    logic [1:0]    state_q, state_d;
    logic [7:0]    note_q, note_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [8:0]    rem_q, rem_d;
`ifdef NOTE_SEQ_GAP_EN
    logic [8:0]    gap_q, gap_d;
`endif

    logic          push;
    logic          pop;
    logic          do_load;
    logic          wrap;
    logic [15:0]   head;
    logic [8:0]    head_ticks;

    assign head       = mem_q[rd_ptr_q];
    assign head_ticks = (head[7:0] == 8'h00) ? 9'd256 : {1'b0, head[7:0]};
    assign push       = WR && !full_q && !STOP;
    assign wrap       = (presc_q == PRESC_LAST);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (STOP) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
            if (WR && full_q) begin
                ovf_d = 1'b1;
            end
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == COUNT_FULL);
    end

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        busy_d  = busy_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        do_load = 1'b0;
`ifdef NOTE_SEQ_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            S_PLAY: begin
                presc_d = wrap ? '0 : presc_q + PW'(1);
                if (wrap) begin
                    if (rem_q == 9'd1) begin
                        if (GAP_ON) begin
`ifdef NOTE_SEQ_GAP_EN
                            state_d = S_GAP;
                            note_d  = 8'h00;
                            gap_d   = GAP_LOAD;
`endif
                        end else if (!empty_q) begin
                            do_load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            note_d  = 8'h00;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        rem_d = rem_q - 9'd1;
                    end
                end
            end
`ifdef NOTE_SEQ_GAP_EN
            S_GAP: begin
                presc_d = wrap ? '0 : presc_q + PW'(1);
                if (wrap) begin
                    if (gap_q == 9'd1) begin
                        if (!empty_q) begin
                            do_load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        gap_d = gap_q - 9'd1;
                    end
                end
            end
`endif
            default: begin
                note_d  = 8'h00;
                busy_d  = 1'b0;
                presc_d = '0;
                rem_d   = '0;
                if (!empty_q) begin
                    do_load = 1'b1;
                end
            end
        endcase

        if (do_load) begin
            state_d = S_PLAY;
            note_d  = head[15:8];
            busy_d  = 1'b1;
            presc_d = '0;
            rem_d   = head_ticks;
        end

        // STOP overrides any load or count decided above.
        pop = do_load && !STOP;
        if (STOP) begin
            state_d = S_IDLE;
            note_d  = 8'h00;
            busy_d  = 1'b0;
            presc_d = '0;
            rem_d   = '0;
`ifdef NOTE_SEQ_GAP_EN
            gap_d   = '0;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            note_q   <= 8'h00;
            busy_q   <= 1'b0;
            presc_q  <= '0;
            rem_q    <= '0;
`ifdef NOTE_SEQ_GAP_EN
            gap_q    <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            note_q   <= note_d;
            busy_q   <= busy_d;
            presc_q  <= presc_d;
            rem_q    <= rem_d;
`ifdef NOTE_SEQ_GAP_EN
            gap_q    <= gap_d;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[wr_ptr_q] <= WR_DATA;
        end
    end

    assign NOTE  = note_q;
    assign BUSY  = busy_q;
    assign EMPTY = empty_q;
    assign FULL  = full_q;
    assign COUNT = count_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a schedule model predicts playback segments and FIFO occupancy,
// and a negedge monitor consumes the expected segments while the DUT plays.
module tb_note_sequencer;
    localparam int DEPTH     = 4;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 1;
    localparam int CW        = $clog2(DEPTH) + 1;
`ifdef NOTE_SEQ_GAP_EN
    localparam int GAP_CYC = GAP_TICKS * TICK_DIV;
`else
    localparam int GAP_CYC = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          WR = 1'b0;
    logic [15:0]   WR_DATA = 16'h0000;
    logic          STOP = 1'b0;
    logic [7:0]    NOTE;
    logic          BUSY;
    logic          EMPTY;
    logic          FULL;
    logic [CW-1:0] COUNT;
    logic          OVF;

    note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
        .CLK(CLK), .RST(RST), .WR(WR), .WR_DATA(WR_DATA), .STOP(STOP),
        .NOTE(NOTE), .BUSY(BUSY), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         start_c;
        int         end_c;
        logic [7:0] note;
    } seg_t;

    seg_t exp_q[$];   // expected output segments [start_c, end_c), busy throughout
    int   pop_q[$];   // cycle on which each queued entry leaves the FIFO
    int   checks = 0;
    int   errors = 0;
    int   prev_end = 0;
    bit   m_ovf = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    always @(negedge CLK) begin : monitor
        logic [7:0] en;
        logic       eb;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].end_c <= cyc) void'(exp_q.pop_front());
            en = 8'h00;
            eb = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].start_c <= cyc) begin
                en = exp_q[0].note;
                eb = 1'b1;
            end
            check("note", {24'h0, NOTE}, {24'h0, en});
            check("busy", {31'h0, BUSY}, {31'h0, eb});
        end
    end

    task automatic step(input bit wr, input logic [15:0] data, input bit stop);
        int   t;
        int   mc;
        int   start;
        int   dur;
        seg_t s;
        t = cyc;
        while (pop_q.size() > 0 && pop_q[0] < t) void'(pop_q.pop_front());
        mc = pop_q.size();
        check("count", 32'(COUNT), 32'(mc));
        check("empty", {31'h0, EMPTY}, {31'h0, mc == 0});
        check("full",  {31'h0, FULL},  {31'h0, mc == DEPTH});
        check("ovf",   {31'h0, OVF},   {31'h0, m_ovf});
        WR = wr;
        WR_DATA = data;
        STOP = stop;
        if (stop) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].start_c >= t + 1) exp_q.delete(i);
                else if (exp_q[i].end_c > t + 1) exp_q[i].end_c = t + 1;
            end
            pop_q.delete();
            m_ovf = 1'b0;
            if (prev_end > t + 1) prev_end = t + 1;
        end else if (wr) begin
            if (mc == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                dur = (data[7:0] == 8'h00) ? 256 : int'(data[7:0]);
                start = (t + 2 > prev_end) ? t + 2 : prev_end;
                pop_q.push_back(start - 1);
                s.start_c = start;
                s.end_c = start + dur * TICK_DIV;
                s.note = data[15:8];
                exp_q.push_back(s);
                prev_end = s.end_c;
                if (GAP_CYC > 0) begin
                    s.start_c = prev_end;
                    s.end_c = prev_end + GAP_CYC;
                    s.note = 8'h00;
                    exp_q.push_back(s);
                    prev_end = s.end_c;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
    endtask

    initial begin : stim
        int         r;
        int         d;
        logic [7:0] dur8;
        logic [7:0] nt;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_note",  {24'h0, NOTE}, 32'h0);
        check("rst_busy",  {31'h0, BUSY}, 32'h0);
        check("rst_empty", {31'h0, EMPTY}, 32'h1);
        check("rst_full",  {31'h0, FULL}, 32'h0);
        check("rst_count", 32'(COUNT), 32'h0);
        check("rst_ovf",   {31'h0, OVF}, 32'h0);
        RST = 1'b0;

        step(1'b1, 16'h0A03, 1'b0);
        idle(16);
        step(1'b1, 16'h0101, 1'b0);
        step(1'b1, 16'h0D02, 1'b0);
        idle(20);

        // overflow: five writes while a note is playing
        step(1'b1, 16'h0A03, 1'b0);
        idle(2);
        for (int i = 0; i < 5; i++) step(1'b1, {8'h20 + 8'(i), 8'd1}, 1'b0);
        idle(40);

        // STOP with a concurrent WR during a 256-tick note, two entries queued
        step(1'b1, 16'h1100, 1'b0);
        idle(3);
        step(1'b1, 16'h1201, 1'b0);
        step(1'b1, 16'h1301, 1'b0);
        idle(40);
        step(1'b1, 16'h1401, 1'b1);
        idle(5);

        step(1'b1, 16'h0002, 1'b0);
        step(1'b1, 16'h2201, 1'b0);
        idle(20);

        // write on the last cycle of a note, then one cycle earlier
        step(1'b1, 16'h0501, 1'b0);
        idle(4 + GAP_CYC);
        step(1'b1, 16'h0601, 1'b0);
        idle(12);
        step(1'b1, 16'h0701, 1'b0);
        idle(3 + GAP_CYC);
        step(1'b1, 16'h4001, 1'b0);
        idle(16);

        for (int k = 0; k < 500; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                step(1'b0, 16'h0000, 1'b1);
            end else if (r < 22) begin
                d = int'($urandom_range(0, 24));
                dur8 = (d == 0) ? 8'd0 : 8'(1 + d % 3);
                nt = 8'($urandom_range(0, 63));
                step(1'b1, {nt, dur8}, 1'b0);
            end else begin
                step(1'b0, 16'h0000, 1'b0);
            end
        end

        for (int k = 0; k < 8000 && cyc <= prev_end + 3; k++) step(1'b0, 16'h0000, 1'b0);
        check("drain_done", {31'h0, cyc > prev_end + 3}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
